// File: rtl/fifo_rd_stream_if.sv
// Read-side handshake bundle: async FIFO read port on one side, framed valid/ready stream on the other.
interface fifo_rd_stream_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 32
);
  logic             fifoEmpty;
  logic [DW-1:0]    fifoRdData;
  logic             fifoRdEn;
  logic             outValid;
  logic             outReady;
  logic [DW-1:0]    outData;
  logic             outLast;
  logic [CNT_W-1:0] wordCount;

  modport master (
    input  fifoEmpty, fifoRdData, outReady,
    output fifoRdEn, outValid, outData, outLast, wordCount
  );

  modport slave (
    output fifoEmpty, fifoRdData, outReady,
    input  fifoRdEn, outValid, outData, outLast, wordCount
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains the FIFO read port into a 2-entry queue and presents it as a framed valid/ready stream.
module fifo_rd_stream #(
  parameter int DW      = 32,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 32
) (
  input  logic clk,
  input  logic rst,
  fifo_rd_stream_if.master bus
);
  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

  logic [DW-1:0]    head;
  logic [DW-1:0]    tail;
  logic [1:0]       occ;
  logic             in_flight;
  logic [IDX_W-1:0] pkt_idx;
  logic [CNT_W-1:0] word_cnt;
  logic             pop;
  logic             rd_en;
  logic [2:0]       pending;

  assign pop     = (occ != 2'd0) && bus.outReady;
  // Credit check counts the word already in flight so the queue can never be overrun.
  assign pending = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
  assign rd_en   = !bus.fifoEmpty && !rst && (pending < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      occ       <= 2'd0;
      in_flight <= 1'b0;
      pkt_idx   <= '0;
      word_cnt  <= '0;
    end else begin
      in_flight <= rd_en;
      unique case ({pop, in_flight})
        2'b10: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) head <= bus.fifoRdData;
          else             tail <= bus.fifoRdData;
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= bus.fifoRdData;
          end else begin
            head <= tail;
            tail <= bus.fifoRdData;
          end
        end
        default: ;
      endcase
      if (pop) begin
        pkt_idx  <= (pkt_idx == IDX_LAST) ? '0 : pkt_idx + IDX_W'(1);
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.fifoRdEn  = rd_en;
  assign bus.outValid  = (occ != 2'd0);
  assign bus.outData   = head;
  assign bus.outLast   = (occ != 2'd0) && (pkt_idx == IDX_LAST);
  assign bus.wordCount = word_cnt;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model and in-order scoreboard with random backpressure.
module tb_fifo_rd_stream;
  localparam int DW      = 32;
  localparam int PKT_LEN = 8;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DW(DW), .CNT_W(CNT_W)) ifc ();

  fifo_rd_stream #(.DW(DW), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_acc, n_reads, n_last, last_at;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard: every accepted word must be the next one pushed since reset.
  task automatic sample();
    if (rst) return;
    if (ifc.fifoEmpty) chk("rden_while_empty", ifc.fifoRdEn, 0);
    if (ifc.fifoRdEn && !ifc.fifoEmpty) n_reads++;
    if (ifc.outValid && ifc.outReady) begin
      chk("word_expected", n_acc < exp_q.size(), 1);
      if (n_acc < exp_q.size()) chk("order", ifc.outData, exp_q[n_acc]);
      chk("last_flag", ifc.outLast, (n_acc % PKT_LEN) == PKT_LEN - 1);
      if (ifc.outLast) begin
        n_last++;
        last_at = n_acc + 1;
      end
      n_acc++;
    end
    chk("outstanding_le2", (n_reads - n_acc) <= 2, 1);
  endtask

  task automatic step();
    bit fire;
    @(negedge clk);
    sample();
    fire = ifc.fifoRdEn && !ifc.fifoEmpty && (fifo_q.size() > 0);
    @(posedge clk);
    #1;
    if (fire) ifc.fifoRdData = fifo_q.pop_front();
    ifc.fifoEmpty = (fifo_q.size() == 0);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    ifc.fifoEmpty = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    ifc.fifoEmpty = 1'b1;
    n_acc = 0; n_reads = 0; n_last = 0; last_at = 0;
    #1;
    chk("rst_rden", ifc.fifoRdEn, 0);
    repeat (cycles) step();
    chk("rst_valid", ifc.outValid, 0);
    chk("rst_wordcount", ifc.wordCount, 0);
    chk("rst_last", ifc.outLast, 0);
    chk("rst_data", ifc.outData, 0);
    rst = 1'b0;
    #1;
  endtask

  task automatic drain(input bit rnd, input int limit);
    int k = 0;
    while (n_acc < exp_q.size() && k < limit) begin
      ifc.outReady = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      step();
      k++;
    end
    chk("drain_complete", n_acc, exp_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int pushed, k;
    rst = 1'b1;
    ifc.outReady   = 1'b0;
    ifc.fifoEmpty  = 1'b1;
    ifc.fifoRdData = '0;
    do_reset(2);

    // latency and basic ordering
    do_reset(1);
    ifc.outReady = 1'b1;
    push(32'h11); push(32'h22); push(32'h33);
    #1;
    chk("lat_rden", ifc.fifoRdEn, 1);
    step(); chk("lat_valid_n1", ifc.outValid, 0);
    step(); chk("lat_valid_n2", ifc.outValid, 1); chk("lat_d0", ifc.outData, 32'h11);
    step(); chk("lat_d1", ifc.outData, 32'h22);
    step(); chk("lat_d2", ifc.outData, 32'h33);
    step(); chk("lat_idle", ifc.outValid, 0);
    chk("lat_count", ifc.wordCount, 3);
    chk("lat_nolast", n_last, 0);

    // full rate with framing
    do_reset(1);
    ifc.outReady = 1'b1;
    for (int i = 0; i < 16; i++) push(DW'(i));
    #1;
    for (int j = 0; j < 10 && !ifc.outValid; j++) step();
    chk("fr_first", ifc.outValid, 1);
    for (int i = 0; i < 16; i++) begin
      chk("fr_nobubble", ifc.outValid, 1);
      chk("fr_data", ifc.outData, i);
      step();
    end
    chk("fr_count", ifc.wordCount, 16);
    chk("fr_lasts", n_last, 2);
    chk("fr_last_at", last_at, 16);

    // backpressure
    do_reset(1);
    ifc.outReady = 1'b0;
    for (int i = 0; i < 10; i++) push($urandom);
    #1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 3) chk("bp_hold", ifc.outData, exp_q[0]);
    end
    chk("bp_reads", n_reads, 2);
    chk("bp_rden", ifc.fifoRdEn, 0);
    chk("bp_valid", ifc.outValid, 1);
    drain(1'b0, 60);
    chk("bp_count", ifc.wordCount, 10);

    // random ready and random arrivals
    do_reset(1);
    pushed = 0;
    k = 0;
    while ((pushed < 100 || n_acc < exp_q.size()) && k < 3000) begin
      if (pushed < 100 && $urandom_range(1, 0) == 1) begin
        push($urandom);
        pushed++;
      end
      ifc.outReady = 1'($urandom_range(1, 0));
      #1;
      step();
      k++;
    end
    chk("rnd_acc", n_acc, 100);
    chk("rnd_count", ifc.wordCount, 100);

    // FIFO starves mid-packet
    do_reset(1);
    ifc.outReady = 1'b1;
    for (int i = 0; i < 5; i++) push($urandom);
    drain(1'b0, 40);
    for (int i = 0; i < 10; i++) begin
      chk("starve_gap", ifc.outValid, 0);
      step();
    end
    for (int i = 0; i < 3; i++) push($urandom);
    drain(1'b0, 40);
    chk("starve_last_at", last_at, 8);
    chk("starve_lasts", n_last, 1);
    chk("starve_count", ifc.wordCount, 8);

    // reset in the middle of a stream
    do_reset(1);
    for (int i = 0; i < 20; i++) push($urandom);
    for (int i = 0; i < 6; i++) begin
      ifc.outReady = 1'($urandom_range(1, 0));
      #1;
      step();
    end
    do_reset(2);
    ifc.outReady = 1'b1;
    for (int i = 0; i < 8; i++) push(32'hA0 + DW'(i));
    drain(1'b0, 40);
    chk("mr_acc", n_acc, 8);
    chk("mr_last_at", last_at, 8);
    chk("mr_count", ifc.wordCount, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
